// File: rtl/dist_ram_dp.sv
// Dual-port distributed RAM: one synchronous write port, two asynchronous read ports
// and a registered copy of DPO. A sequencer fills the array with CLR_VAL after reset or on CLR.
module dist_ram_dp #(
    parameter int unsigned            WIDTH   = 8,
    parameter int unsigned            AWIDTH  = 4,
    parameter logic [WIDTH-1:0]       CLR_VAL = {WIDTH{1'b0}}
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [AWIDTH-1:0] A,
    input  logic [WIDTH-1:0]  D,
    input  logic              WE,
    input  logic [AWIDTH-1:0] DPRA,
    input  logic              CLR,
    output logic [WIDTH-1:0]  SPO,
    output logic [WIDTH-1:0]  DPO,
    output logic [WIDTH-1:0]  DPO_R,
    output logic              BUSY
);

    localparam int unsigned       DEPTH    = 2 ** AWIDTH;
    localparam logic [AWIDTH-1:0] LAST_ADR = AWIDTH'(DEPTH - 1);
    localparam logic [AWIDTH-1:0] ONE      = AWIDTH'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [AWIDTH-1:0]   cnt_r;
    logic [AWIDTH-1:0]   cnt_nxt_s;
    logic [WIDTH-1:0]    dpo_r;
    logic                mem_we_s;
    logic [AWIDTH-1:0]   mem_adr_s;
    logic [WIDTH-1:0]    mem_dat_s;
    logic [WIDTH-1:0]    mem_r [DEPTH];

    // Next-state logic and the single write port shared by the sequencer and the user.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        mem_we_s    = 1'b0;
        mem_adr_s   = A;
        mem_dat_s   = D;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = {AWIDTH{1'b0}};
                if (CLR) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_IDLE;
                    mem_we_s    = WE;
                end
            end
            ST_CLEAR: begin
                mem_we_s  = 1'b1;
                mem_adr_s = cnt_r;
                mem_dat_s = CLR_VAL;
                cnt_nxt_s = cnt_r + ONE;
                if (cnt_r == LAST_ADR) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            default: begin
                state_nxt_s = ST_CLEAR;
                cnt_nxt_s   = {AWIDTH{1'b0}};
            end
        endcase
    end

    // Sequencer state, clear counter and registered DPO copy.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_CLEAR;
            cnt_r   <= {AWIDTH{1'b0}};
            dpo_r   <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            dpo_r   <= DPO;
        end
    end

    // Array has no reset; writes are suppressed while reset is held.
    always_ff @(posedge CLK) begin
        if (mem_we_s && RST_N) begin
            mem_r[mem_adr_s] <= mem_dat_s;
        end
    end

    assign SPO   = mem_r[A];
    assign DPO   = mem_r[DPRA];
    assign DPO_R = dpo_r;
    assign BUSY  = (state_r == ST_CLEAR);

endmodule

// File: tb/tb_dist_ram_dp.sv
// Directed bench for dist_ram_dp: a 16x8 instance (CLR_VAL=A5) and a 2x1 instance (CLR_VAL=1).
module tb_dist_ram_dp;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a, dpra;
    logic [7:0] d;
    logic       we, clr;
    logic [7:0] spo, dpo, dpo_r;
    logic       busy;

    logic       rst2_n;
    logic       a2, dpra2, d2, we2, clr2;
    logic       spo2, dpo2, dpo_r2, busy2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dist_ram_dp #(.WIDTH(8), .AWIDTH(4), .CLR_VAL(8'hA5)) dut (
        .CLK(clk), .RST_N(rst_n), .A(a), .D(d), .WE(we), .DPRA(dpra), .CLR(clr),
        .SPO(spo), .DPO(dpo), .DPO_R(dpo_r), .BUSY(busy)
    );

    dist_ram_dp #(.WIDTH(1), .AWIDTH(1), .CLR_VAL(1'b1)) dut_s (
        .CLK(clk), .RST_N(rst2_n), .A(a2), .D(d2), .WE(we2), .DPRA(dpra2), .CLR(clr2),
        .SPO(spo2), .DPO(dpo2), .DPO_R(dpo_r2), .BUSY(busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until BUSY drops; optional CLR pulse during the clear.
    task automatic count_busy(output int n, input bit pulse_clr);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (pulse_clr && n == 5) clr = 1'b1;
            tick();
            clr = 1'b0;
            n++;
            if (busy !== 1'b1) we = 1'b0;
        end
    endtask

    task automatic check_all_a5(input string name);
        for (int i = 0; i < 16; i++) begin
            a    = 4'(i);
            dpra = 4'(15 - i);
            #1;
            total++;
            if (spo !== 8'hA5 || dpo !== 8'hA5) begin
                bad++;
                $display("FAIL %s addr=%0d spo=%h dpo=%h required a5", name, i, spo, dpo);
            end
        end
    endtask

    task automatic test_reset();
        int n;
        #12;
        total++;
        if (busy !== 1'b1 || dpo_r !== 8'h00) begin
            bad++;
            $display("FAIL reset_state busy=%b dpo_r=%h required 1/00", busy, dpo_r);
        end
        we = 1'b1; a = 4'd3; d = 8'h11;
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(n, 1'b0);
        total++;
        if (n != 16) begin
            bad++;
            $display("FAIL reset_busy_len edges=%0d required 16", n);
        end
        we = 1'b0;
        check_all_a5("reset_fill");
    endtask

    task automatic test_write_read();
        a = 4'd7; dpra = 4'd7; d = 8'h3C; we = 1'b1;
        tick();
        we = 1'b0;
        total++;
        if (spo !== 8'h3C || dpo !== 8'h3C) begin
            bad++;
            $display("FAIL wr_async spo=%h dpo=%h required 3c", spo, dpo);
        end
        total++;
        if (dpo_r !== 8'hA5) begin
            bad++;
            $display("FAIL wr_dpo_r_old dpo_r=%h required a5", dpo_r);
        end
        tick();
        total++;
        if (dpo_r !== 8'h3C) begin
            bad++;
            $display("FAIL wr_dpo_r_new dpo_r=%h required 3c", dpo_r);
        end
    endtask

    task automatic test_collision();
        a = 4'd5; d = 8'h00; we = 1'b1; dpra = 4'd5;
        tick();
        we = 1'b0;
        tick();
        total++;
        if (dpo_r !== 8'h00) begin
            bad++;
            $display("FAIL coll_pre dpo_r=%h required 00", dpo_r);
        end
        d = 8'hFF; we = 1'b1;
        tick();
        we = 1'b0;
        total++;
        if (dpo_r !== 8'h00 || dpo !== 8'hFF) begin
            bad++;
            $display("FAIL coll_edge dpo_r=%h dpo=%h required 00/ff", dpo_r, dpo);
        end
        tick();
        total++;
        if (dpo_r !== 8'hFF) begin
            bad++;
            $display("FAIL coll_next dpo_r=%h required ff", dpo_r);
        end
    endtask

    task automatic test_clr_we();
        int n;
        clr = 1'b1; we = 1'b1; a = 4'd2; d = 8'h77;
        tick();
        clr = 1'b0; we = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL clr_busy busy=%b required 1", busy);
        end
        count_busy(n, 1'b1);
        total++;
        if (n != 16) begin
            bad++;
            $display("FAIL clr_busy_len edges=%0d required 16", n);
        end
        check_all_a5("clr_fill");
    endtask

    task automatic test_reset_mid();
        int n;
        a = 4'd12; d = 8'h5A; we = 1'b1;
        tick();
        we = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b1 || dpo_r !== 8'h00) begin
            bad++;
            $display("FAIL midrst_state busy=%b dpo_r=%h required 1/00", busy, dpo_r);
        end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(n, 1'b0);
        total++;
        if (n != 16) begin
            bad++;
            $display("FAIL midrst_busy_len edges=%0d required 16", n);
        end
        check_all_a5("midrst_fill");
    endtask

    task automatic test_sweep();
        int n;
        @(negedge clk);
        rst2_n = 1'b1;
        n = 0;
        while (busy2 === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (n != 2) begin
            bad++;
            $display("FAIL sweep_busy_len edges=%0d required 2", n);
        end
        a2 = 1'b0; dpra2 = 1'b1;
        #1;
        total++;
        if (spo2 !== 1'b1 || dpo2 !== 1'b1) begin
            bad++;
            $display("FAIL sweep_fill spo=%b dpo=%b required 1/1", spo2, dpo2);
        end
        a2 = 1'b1; d2 = 1'b0; we2 = 1'b1;
        tick();
        we2 = 1'b0; a2 = 1'b0;
        #1;
        total++;
        if (dpo2 !== 1'b0 || spo2 !== 1'b1) begin
            bad++;
            $display("FAIL sweep_write dpo=%b spo=%b required 0/1", dpo2, spo2);
        end
    endtask

    initial begin
        rst_n = 1'b0; a = 4'd0; dpra = 4'd0; d = 8'h00; we = 1'b0; clr = 1'b0;
        rst2_n = 1'b0; a2 = 1'b0; dpra2 = 1'b0; d2 = 1'b0; we2 = 1'b0; clr2 = 1'b0;
        test_reset();
        test_write_read();
        test_collision();
        test_clr_we();
        test_reset_mid();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dist_ram_dp.md
# dist_ram_dp

Parametrised dual-port distributed RAM: one synchronous write port, two asynchronous read ports, plus a registered copy of the second read port. It adds a hardware clear sequencer that fills the whole array with a programmable value after reset or on request. It replaces fixed 16x1 primitives in register files and small buffers of the CPU core, where the wide per-bit instances had to be cleared by software.

## Interface
- WIDTH, 8, data width in bits (1..64)
- AWIDTH, 4, address width; DEPTH = 2**AWIDTH locations (1..8)
- CLR_VAL, {WIDTH{1'b0}}, value written to every location by the clear sequencer
- CLK  in  1  single clock; all writes and registers use its rising edge
- RST_N  in  1  asynchronous, active-low reset
- A  in  AWIDTH  write address and SPO read address
- D  in  WIDTH  write data
- WE  in  1  write enable, sampled at CLK rise
- DPRA  in  AWIDTH  dual-port read address
- CLR  in  1  clear request, sampled at CLK rise
- SPO  out  WIDTH  asynchronous read of mem[A]
- DPO  out  WIDTH  asynchronous read of mem[DPRA]
- DPO_R  out  WIDTH  DPO registered at CLK rise
- BUSY  out  1  clear sequencer active; user writes ignored

## Operation
- Array is DEPTH x WIDTH. It has no reset and is not initialised; contents are X in simulation until the first clear completes.
- Sequencer states:
  - IDLE -> CLEAR on reset release, or on CLR=1 sampled in IDLE.
  - CLEAR -> IDLE after writing the location at address DEPTH-1.
- CLEAR behaviour:
  - An internal counter cnt[AWIDTH-1:0] starts at 0.
  - Each cycle writes CLR_VAL to mem[cnt] and increments cnt.
  - The transition to IDLE happens on the edge that writes cnt = DEPTH-1; cnt wraps to 0.
- BUSY = 1 exactly while in CLEAR.
- User write in IDLE: WE=1 at a CLK rise writes mem[A] <= D.
- Ignored writes: WE is ignored in CLEAR, and in the IDLE cycle where CLR=1 (CLR wins and the write is dropped).
- CLR sampled in CLEAR is ignored; the clear is not restarted.
- SPO and DPO are purely combinational from the array and addresses. They remain live during CLEAR and show partially cleared contents.
- When A == DPRA, SPO == DPO at all times.
- DPO_R <= DPO on every CLK rise, in both states.

## Timing
- Reset values while RST_N=0: state=CLEAR, cnt=0, BUSY=1, DPO_R=0. No array writes occur during reset.
- Clear after reset: the first rising edge with RST_N=1 writes address 0. The DEPTH-th edge writes address DEPTH-1 and drops BUSY. The first user write is accepted on edge DEPTH+1.
- Clear after CLR: CLR=1 at edge k (IDLE) sets BUSY=1 after edge k. Addresses 0..DEPTH-1 are written on edges k+1..k+DEPTH. BUSY=0 after edge k+DEPTH.
- Write-to-read latency:
  - SPO/DPO show new data immediately after the writing edge (plus combinational delay).
  - DPO_R shows it one edge later.
- Read-during-write to the same address in the same cycle:
  - SPO/DPO show old data before the edge and new data after it.
  - DPO_R captures the old data at that edge.
- Reset mid-clear: RST_N low asynchronously forces cnt=0, DPO_R=0, BUSY=1. The clear restarts from address 0 on release. Locations already written keep CLR_VAL.

## Test plan
- Reset release (WIDTH=8, AWIDTH=4, CLR_VAL=8'hA5):
  - BUSY=1 for exactly 16 edges.
  - Then every A/DPRA reads 8'hA5.
  - WE=1, A=3, D=8'h11 while BUSY is ignored; mem[3] stays 8'hA5.
- Write/read in IDLE:
  - Write 8'h3C to address 7 -> SPO (A=7) = 8'h3C right after the edge.
  - DPRA=7 -> DPO=8'h3C, and DPO_R=8'h3C one edge later.
- Same-address collision:
  - Address 5 holds 8'h00; with DPRA=5, write 8'hFF at edge k.
  - Required: DPO_R = 8'h00 after edge k and 8'hFF after edge k+1.
- CLR with WE in the same cycle: CLR=1 and WE=1 (A=2, D=8'h77) -> write dropped, BUSY high for 16 edges, mem[2]=8'hA5.
- Reset mid-clear:
  - Assert RST_N=0 after cnt reaches 9 -> BUSY stays 1, DPO_R=0.
  - After release, BUSY lasts 16 full edges and all locations read 8'hA5.
- Parameter sweep (WIDTH=1, AWIDTH=1, CLR_VAL=1) -> BUSY lasts 2 edges; both locations read 1; write 0 to address 1 -> DPO (DPRA=1) = 0.
